fetch_stage: RTL and testbench

//  IF stage and IF/ID pipeline register, directly upstream of hazard_unit's consumers.

---
 rtl/fetch_stage_pkg.sv | 18 +
 rtl/fetch_stage_if.sv | 22 ++
 rtl/fetch_skid_buf.sv | 34 +++
 rtl/fetch_stage.sv | 116 +++++++++++
 tb/tb_fetch_stage.sv | 335 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared constants, FSM encoding and helpers for the IF stage.
// Imported by fetch_stage, fetch_skid_buf and fetch_stage_if.
package fetch_stage_pkg;

    localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        KILL = 2'd2
    } fetchState_t;

    function automatic logic [31:0] pcPlus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/grant plus response channel.
// The fetch stage is master, the memory is slave.
interface fetch_stage_if;
    import fetch_stage_pkg::*;

    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req, addr,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, addr,
        output gnt, rvalid, rdata
    );

endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry {instr, pc} holding buffer for responses caught by a D stall.
// Clear beats load, load beats drain.
module fetch_skid_buf
    import fetch_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        drain,
    input  logic        clear,
    input  logic [31:0] instrIn,
    input  logic [31:0] pcIn,
    output logic        bufValid,
    output logic [31:0] bufInstr,
    output logic [31:0] bufPc
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bufValid <= 1'b0;
            bufInstr <= DEF_NOP_INSTR;
            bufPc    <= 32'd0;
        end else if (clear) begin
            bufValid <= 1'b0;
        end else if (load) begin
            bufValid <= 1'b1;
            bufInstr <= instrIn;
            bufPc    <= pcIn;
        end else if (drain) begin
            bufValid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns PCF, single-outstanding imem fetch FSM, and the IF/ID register.
// A redirect turns an in-flight request into KILL so its response is discarded.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
    parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          StallF,
    input  logic          StallD,
    input  logic          FlushD,
    input  logic          PCSrcE,
    input  logic [31:0]   PCTargetE,
    fetch_stage_if.master imem,
    output logic [31:0]   InstrD,
    output logic [31:0]   PCD,
    output logic [31:0]   PCPlus4D,
    output logic          ValidD,
    output logic          FetchBusyF
);

    fetchState_t state, stateNext;
    logic [31:0] pcF;
    logic [31:0] reqPc;
    logic        fire;
    logic        live;
    logic        bufValid;
    logic [31:0] bufInstr;
    logic [31:0] bufPc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        if (PCSrcE) begin
            if (imem.rvalid)        stateNext = IDLE;
            else if (state != IDLE) stateNext = KILL;
            else                    stateNext = IDLE;
        end else begin
            unique case (state)
                IDLE: if (fire) stateNext = WAIT;
                WAIT: if (imem.rvalid) stateNext = fire ? WAIT : IDLE;
                KILL: if (imem.rvalid) stateNext = IDLE;
                default: stateNext = IDLE;
            endcase
        end
    end

    always_comb begin
        imem.req = reset && !StallF && !PCSrcE && !bufValid && !StallD
                && (state == IDLE || (state == WAIT && imem.rvalid));
        fire       = imem.req && imem.gnt;
        live       = (state == WAIT) && imem.rvalid && !PCSrcE;
        FetchBusyF = (state != IDLE);
        imem.addr  = pcF;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pcF   <= RESET_PC;
            reqPc <= 32'd0;
        end else if (PCSrcE) begin
            pcF   <= PCTargetE;
        end else if (fire) begin
            pcF   <= pcPlus4(pcF);
            reqPc <= pcF;
        end
    end

    fetch_skid_buf uSkid (
        .clk      (clk),
        .reset    (reset),
        .load     (live && StallD),
        .drain    (bufValid && !StallD && !FlushD),
        .clear    (PCSrcE),
        .instrIn  (imem.rdata),
        .pcIn     (reqPc),
        .bufValid (bufValid),
        .bufInstr (bufInstr),
        .bufPc    (bufPc)
    );

    // Stall wins over flush; PCD/PCPlus4D keep their last value on bubbles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            InstrD   <= NOP_INSTR;
            PCD      <= 32'd0;
            PCPlus4D <= 32'd0;
            ValidD   <= 1'b0;
        end else if (!StallD) begin
            if (FlushD) begin
                InstrD <= NOP_INSTR;
                ValidD <= 1'b0;
            end else if (bufValid && !PCSrcE) begin
                InstrD   <= bufInstr;
                PCD      <= bufPc;
                PCPlus4D <= pcPlus4(bufPc);
                ValidD   <= 1'b1;
            end else if (live) begin
                InstrD   <= imem.rdata;
                PCD      <= reqPc;
                PCPlus4D <= pcPlus4(reqPc);
                ValidD   <= 1'b1;
            end else begin
                InstrD <= NOP_INSTR;
                ValidD <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a latency-programmable imem model.
// Instruction word returned for address A is A + 0x1000_0000.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        StallF = 1'b0, StallD = 1'b0, FlushD = 1'b0;
    logic        PCSrcE = 1'b0;
    logic [31:0] PCTargetE = 32'd0;
    logic [31:0] InstrD, PCD, PCPlus4D;
    logic        ValidD, FetchBusyF;
    logic        gntEn = 1'b1;
    int          lat = 1;
    logic [1:0]  memCnt;
    logic [31:0] memAddr;
    int          testsRun = 0;
    int          testsFailed = 0;

    fetch_stage_if imem ();

    fetch_stage dut (
        .clk        (clk),
        .reset      (reset),
        .StallF     (StallF),
        .StallD     (StallD),
        .FlushD     (FlushD),
        .PCSrcE     (PCSrcE),
        .PCTargetE  (PCTargetE),
        .imem       (imem.master),
        .InstrD     (InstrD),
        .PCD        (PCD),
        .PCPlus4D   (PCPlus4D),
        .ValidD     (ValidD),
        .FetchBusyF (FetchBusyF)
    );

    always #5 clk = ~clk;

    assign imem.gnt    = gntEn;
    assign imem.rvalid = (memCnt == 2'd1);
    assign imem.rdata  = memAddr + 32'h1000_0000;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            memCnt  <= 2'd0;
            memAddr <= 32'd0;
        end else if (imem.req && imem.gnt) begin
            memCnt  <= 2'(lat);
            memAddr <= imem.addr;
        end else if (memCnt != 2'd0) begin
            memCnt  <= memCnt - 2'd1;
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset;
        StallF = 0; StallD = 0; FlushD = 0;
        PCSrcE = 0; PCTargetE = 0;
        gntEn = 1; lat = 1;
        #1 reset = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1;
        #1;
    endtask

    task automatic test_reset;
        StallF = 0; StallD = 0; FlushD = 0; PCSrcE = 0;
        #1 reset = 0;
        #1;
        testsRun++;
        if ({imem.req, ValidD, FetchBusyF} !== 3'b000) begin
            testsFailed++;
            $display("FAIL reset_ctl: req/valid/busy=%b want 000",
                     {imem.req, ValidD, FetchBusyF});
        end
        testsRun++;
        if ({InstrD, PCD, PCPlus4D, imem.addr} !==
            {DEF_NOP_INSTR, 32'd0, 32'd0, DEF_RESET_PC}) begin
            testsFailed++;
            $display("FAIL reset_val: instr=%h pcd=%h p4=%h addr=%h",
                     InstrD, PCD, PCPlus4D, imem.addr);
        end
    endtask

    task automatic test_stream;
        doReset();
        testsRun++;
        if ({imem.req, imem.addr} !== {1'b1, 32'h0}) begin
            testsFailed++;
            $display("FAIL stream_c0: req=%b addr=%h want 1 0",
                     imem.req, imem.addr);
        end
        step(); #1;
        testsRun++;
        if ({imem.req, imem.addr, ValidD} !== {1'b1, 32'h4, 1'b0}) begin
            testsFailed++;
            $display("FAIL stream_c1: req=%b addr=%h v=%b want 1 4 0",
                     imem.req, imem.addr, ValidD);
        end
        step(); #1;
        testsRun++;
        if ({ValidD, PCD, InstrD, imem.addr} !==
            {1'b1, 32'h0, 32'h1000_0000, 32'h8}) begin
            testsFailed++;
            $display("FAIL stream_c2: v=%b pcd=%h instr=%h addr=%h",
                     ValidD, PCD, InstrD, imem.addr);
        end
        step(); #1;
        testsRun++;
        if ({ValidD, PCD, InstrD, PCPlus4D} !==
            {1'b1, 32'h4, 32'h1000_0004, 32'h8}) begin
            testsFailed++;
            $display("FAIL stream_c3: v=%b pcd=%h instr=%h p4=%h",
                     ValidD, PCD, InstrD, PCPlus4D);
        end
        step(); #1;
        testsRun++;
        if ({ValidD, PCD} !== {1'b1, 32'h8}) begin
            testsFailed++;
            $display("FAIL stream_c4: v=%b pcd=%h want 1 8", ValidD, PCD);
        end
    endtask

    task automatic test_stall;
        doReset();
        step();
        StallF = 1; StallD = 1;
        #1;
        for (int i = 0; i < 3; i++) begin
            testsRun++;
            if ({imem.req, ValidD} !== 2'b00) begin
                testsFailed++;
                $display("FAIL stall_hold%0d: req=%b v=%b want 0 0",
                         i, imem.req, ValidD);
            end
            step(); #1;
        end
        StallF = 0; StallD = 0;
        #1;
        testsRun++;
        if (imem.req !== 1'b0) begin
            testsFailed++;
            $display("FAIL stall_bufblock: req=%b want 0", imem.req);
        end
        step(); #1;
        testsRun++;
        if ({ValidD, PCD, InstrD, imem.req, imem.addr} !==
            {1'b1, 32'h0, 32'h1000_0000, 1'b1, 32'h4}) begin
            testsFailed++;
            $display("FAIL stall_drain: v=%b pcd=%h instr=%h req=%b addr=%h",
                     ValidD, PCD, InstrD, imem.req, imem.addr);
        end
        step(); #1;
        testsRun++;
        if (ValidD !== 1'b0) begin
            testsFailed++;
            $display("FAIL stall_gap: v=%b want 0", ValidD);
        end
        step(); #1;
        testsRun++;
        if ({ValidD, PCD, InstrD} !== {1'b1, 32'h4, 32'h1000_0004}) begin
            testsFailed++;
            $display("FAIL stall_next: v=%b pcd=%h instr=%h want 1 4 10000004",
                     ValidD, PCD, InstrD);
        end
    endtask

    task automatic test_redirect_wait;
        doReset();
        lat = 3;
        step();
        PCSrcE = 1; PCTargetE = 32'h100; FlushD = 1;
        #1;
        testsRun++;
        if (imem.req !== 1'b0) begin
            testsFailed++;
            $display("FAIL rdw_req: req=%b want 0", imem.req);
        end
        step();
        PCSrcE = 0; FlushD = 0;
        #1;
        testsRun++;
        if ({FetchBusyF, imem.req, ValidD, imem.addr} !==
            {1'b1, 1'b0, 1'b0, 32'h100}) begin
            testsFailed++;
            $display("FAIL rdw_kill: busy=%b req=%b v=%b addr=%h",
                     FetchBusyF, imem.req, ValidD, imem.addr);
        end
        step();
        lat = 1;
        #1;
        testsRun++;
        if ({imem.rvalid, imem.req} !== 2'b10) begin
            testsFailed++;
            $display("FAIL rdw_drop: rvalid=%b req=%b want 1 0",
                     imem.rvalid, imem.req);
        end
        step(); #1;
        testsRun++;
        if ({ValidD, FetchBusyF, imem.req, imem.addr} !==
            {1'b0, 1'b0, 1'b1, 32'h100}) begin
            testsFailed++;
            $display("FAIL rdw_refetch: v=%b busy=%b req=%b addr=%h",
                     ValidD, FetchBusyF, imem.req, imem.addr);
        end
        step(); #1;
        testsRun++;
        if (ValidD !== 1'b0) begin
            testsFailed++;
            $display("FAIL rdw_gap: v=%b want 0", ValidD);
        end
        step(); #1;
        testsRun++;
        if ({ValidD, PCD, InstrD, PCPlus4D} !==
            {1'b1, 32'h100, 32'h1000_0100, 32'h104}) begin
            testsFailed++;
            $display("FAIL rdw_target: v=%b pcd=%h instr=%h p4=%h",
                     ValidD, PCD, InstrD, PCPlus4D);
        end
    endtask

    task automatic test_redirect_rvalid;
        doReset();
        step();
        PCSrcE = 1; PCTargetE = 32'h200; FlushD = 1;
        #1;
        testsRun++;
        if ({imem.rvalid, imem.req} !== 2'b10) begin
            testsFailed++;
            $display("FAIL rdr_same: rvalid=%b req=%b want 1 0",
                     imem.rvalid, imem.req);
        end
        step();
        PCSrcE = 0; FlushD = 0;
        #1;
        testsRun++;
        if ({FetchBusyF, ValidD, imem.req, imem.addr} !==
            {1'b0, 1'b0, 1'b1, 32'h200}) begin
            testsFailed++;
            $display("FAIL rdr_idle: busy=%b v=%b req=%b addr=%h",
                     FetchBusyF, ValidD, imem.req, imem.addr);
        end
        step(); #1;
        step(); #1;
        testsRun++;
        if ({ValidD, PCD, InstrD} !== {1'b1, 32'h200, 32'h1000_0200}) begin
            testsFailed++;
            $display("FAIL rdr_target: v=%b pcd=%h instr=%h",
                     ValidD, PCD, InstrD);
        end
    endtask

    task automatic test_gnt_low;
        doReset();
        gntEn = 0;
        #1;
        for (int i = 0; i < 4; i++) begin
            testsRun++;
            if ({imem.req, imem.addr, ValidD, FetchBusyF} !==
                {1'b1, 32'h0, 1'b0, 1'b0}) begin
                testsFailed++;
                $display("FAIL gnt_low%0d: req=%b addr=%h v=%b busy=%b",
                         i, imem.req, imem.addr, ValidD, FetchBusyF);
            end
            step(); #1;
        end
        gntEn = 1;
        step(); #1;
        testsRun++;
        if ({imem.addr, FetchBusyF} !== {32'h4, 1'b1}) begin
            testsFailed++;
            $display("FAIL gnt_resume: addr=%h busy=%b want 4 1",
                     imem.addr, FetchBusyF);
        end
    endtask

    task automatic test_reset_mid;
        doReset();
        step(); step(); step();
        PCSrcE = 1; PCTargetE = 32'h3C; lat = 3;
        step();
        PCSrcE = 0;
        #1;
        testsRun++;
        if ({PCD, imem.req, imem.addr} !== {32'h4, 1'b1, 32'h3C}) begin
            testsFailed++;
            $display("FAIL rmid_pre: pcd=%h req=%b addr=%h want 4 1 3c",
                     PCD, imem.req, imem.addr);
        end
        step(); #1;
        testsRun++;
        if ({FetchBusyF, imem.addr} !== {1'b1, 32'h40}) begin
            testsFailed++;
            $display("FAIL rmid_wait: busy=%b addr=%h want 1 40",
                     FetchBusyF, imem.addr);
        end
        reset = 0;
        #1;
        testsRun++;
        if ({imem.req, FetchBusyF, ValidD, InstrD, PCD, PCPlus4D, imem.addr} !==
            {3'b000, DEF_NOP_INSTR, 32'd0, 32'd0, DEF_RESET_PC}) begin
            testsFailed++;
            $display("FAIL rmid_reset: req=%b busy=%b v=%b i=%h pcd=%h p4=%h a=%h",
                     imem.req, FetchBusyF, ValidD, InstrD, PCD, PCPlus4D,
                     imem.addr);
        end
        @(posedge clk);
        #1 reset = 1;
        #1;
        testsRun++;
        if ({imem.req, imem.addr} !== {1'b1, DEF_RESET_PC}) begin
            testsFailed++;
            $display("FAIL rmid_restart: req=%b addr=%h want 1 %h",
                     imem.req, imem.addr, DEF_RESET_PC);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect_wait();
        test_redirect_rvalid();
        test_gnt_low();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
